// File: rtl/lagd_pkg.sv
// Shared definitions for the LAGD island controller: regbus types, register map,
// control/status field positions and the controller FSM encoding.
package lagd_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } lagd_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } lagd_reg_rsp_t;

    // Byte offsets within the island window; only addr[4:2] is decoded.
    localparam logic [4:0] CtrlOffset     = 5'h00;
    localparam logic [4:0] StatusOffset   = 5'h04;
    localparam logic [4:0] NumIterOffset  = 5'h08;
    localparam logic [4:0] TimeoutOffset  = 5'h0C;
    localparam logic [4:0] CycleCntOffset = 5'h10;
    localparam logic [4:0] IdOffset       = 5'h14;

    localparam int unsigned CtrlStartBit  = 0;
    localparam int unsigned CtrlAbortBit  = 1;
    localparam int unsigned CtrlIrqEnBit  = 2;

    localparam int unsigned StatusBusyBit    = 0;
    localparam int unsigned StatusDoneBit    = 1;
    localparam int unsigned StatusTimeoutBit = 2;
    localparam int unsigned StatusAbortedBit = 3;

    localparam int unsigned IslandIdDefault = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRun  = 2'd2
    } lagd_state_e;

endpackage

// File: rtl/lagd_island_ctrl_if.sv
// Regbus request/response bundle for one island register window.
interface lagd_island_ctrl_if;
    import lagd_pkg::*;

    lagd_reg_req_t req;
    lagd_reg_rsp_t rsp;

    modport master (output req, input  rsp);
    modport slave  (input  req, output rsp);

endinterface

// File: rtl/lagd_island_ctrl.sv
// Per-island job controller: regbus register file plus IDLE/REQ/RUN launch FSM.
// Define LAGD_ISLAND_CTRL_TIMEOUT_EN to build the RUN-phase cycle timeout.
module lagd_island_ctrl
    import lagd_pkg::*;
#(
    parameter type         reg_req_t = lagd_pkg::lagd_reg_req_t,
    parameter type         reg_rsp_t = lagd_pkg::lagd_reg_rsp_t,
    parameter int unsigned IslandId  = IslandIdDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  reg_req_t    reg_req_i,
    output reg_rsp_t    reg_rsp_o,
    output logic        core_start_valid_o,
    input  logic        core_start_ready_i,
    output logic [31:0] core_num_iter_o,
    output logic        core_abort_o,
    input  logic        core_done_i,
    output logic        irq_o
);

    lagd_state_e state_q, state_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        aborted_q, aborted_d;
    logic [31:0] num_iter_q, num_iter_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        abort_q, abort_d;
    logic        irq_q, irq_d;
`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
    logic [31:0] timeout_cyc_q, timeout_cyc_d;
    logic        timeout_hit;
`endif

    logic        busy;
    logic [4:0]  reg_off;
    logic        start_wr, abort_wr;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    assign busy    = (state_q != StIdle);
    assign reg_off = {reg_req_i.addr[4:2], 2'b00};

    // Upper/lower address bits and byte strobes are deliberately not decoded.
    logic unused_bits;
    assign unused_bits = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0], reg_req_i.wstrb};

`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
    assign timeout_hit = (timeout_cyc_q != 32'd0) && ((cycle_cnt_q + 32'd1) == timeout_cyc_q);
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d     = state_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        num_iter_d  = num_iter_q;
        cycle_cnt_d = cycle_cnt_q;
        abort_d     = 1'b0;
        start_wr    = 1'b0;
        abort_wr    = 1'b0;
        rsp_rdata   = 32'd0;
        rsp_error   = 1'b0;
`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
        timeout_cyc_d = timeout_cyc_q;
`endif

        if (reg_req_i.valid) begin
            case (reg_off)
                CtrlOffset: begin
                    rsp_rdata[CtrlIrqEnBit] = irq_en_q;
                    if (reg_req_i.write) begin
                        irq_en_d = reg_req_i.wdata[CtrlIrqEnBit];
                        start_wr = reg_req_i.wdata[CtrlStartBit];
                        abort_wr = reg_req_i.wdata[CtrlAbortBit];
                    end
                end
                StatusOffset: begin
                    rsp_rdata[StatusBusyBit]    = busy;
                    rsp_rdata[StatusDoneBit]    = done_q;
                    rsp_rdata[StatusTimeoutBit] = timeout_q;
                    rsp_rdata[StatusAbortedBit] = aborted_q;
                    if (reg_req_i.write) begin
                        if (reg_req_i.wdata[StatusDoneBit])    done_d    = 1'b0;
                        if (reg_req_i.wdata[StatusTimeoutBit]) timeout_d = 1'b0;
                        if (reg_req_i.wdata[StatusAbortedBit]) aborted_d = 1'b0;
                    end
                end
                NumIterOffset: begin
                    rsp_rdata = num_iter_q;
                    if (reg_req_i.write) begin
                        // The core samples NUM_ITER for the whole job, so it is frozen while busy.
                        if (busy) rsp_error  = 1'b1;
                        else      num_iter_d = reg_req_i.wdata;
                    end
                end
                TimeoutOffset: begin
`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
                    rsp_rdata = timeout_cyc_q;
                    if (reg_req_i.write) timeout_cyc_d = reg_req_i.wdata;
`endif
                end
                CycleCntOffset: begin
                    rsp_rdata = cycle_cnt_q;
                    if (reg_req_i.write) rsp_error = 1'b1;
                end
                IdOffset: begin
                    rsp_rdata = 32'(IslandId);
                    if (reg_req_i.write) rsp_error = 1'b1;
                end
                default: rsp_error = 1'b1;
            endcase
        end

        // FSM transitions override the register-side updates above.
        case (state_q)
            StIdle: begin
                if (start_wr) begin
                    state_d     = StReq;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    aborted_d   = 1'b0;
                    cycle_cnt_d = 32'd0;
                end
            end
            StReq: begin
                if (abort_wr) begin
                    abort_d   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (core_start_ready_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 32'd1;
                // Completion outranks both a software abort and a timeout in the same cycle.
                if (core_done_i) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (abort_wr) begin
                    abort_d   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end
`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
                else if (timeout_hit) begin
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        irq_d = irq_en_q & (done_q | timeout_q | aborted_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
            num_iter_q  <= 32'd0;
            cycle_cnt_q <= 32'd0;
            abort_q     <= 1'b0;
            irq_q       <= 1'b0;
`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
            timeout_cyc_q <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
            num_iter_q  <= num_iter_d;
            cycle_cnt_q <= cycle_cnt_d;
            abort_q     <= abort_d;
            irq_q       <= irq_d;
`ifdef LAGD_ISLAND_CTRL_TIMEOUT_EN
            timeout_cyc_q <= timeout_cyc_d;
`endif
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rsp_rdata;
        reg_rsp_o.error = rsp_error;
        reg_rsp_o.ready = 1'b1;
    end

    assign core_start_valid_o = (state_q == StReq);
    assign core_num_iter_o    = num_iter_q;
    assign core_abort_o       = abort_q;
    assign irq_o              = irq_q;

endmodule

// File: doc/lagd_island_ctrl.md
LAGD_ISLAND_CTRL -- requirements
Module: lagd_island_ctrl

Interface
REQ-001 SHALL have parameter reg_req_t, default logic, Cheshire regbus request type (addr, write, wdata[31:0], wstrb[3:0], valid).
REQ-002 SHALL have parameter reg_rsp_t, default logic, regbus response type (rdata[31:0], error, ready).
REQ-003 SHALL have parameter IslandId, default 0, island index returned in the ID register.
REQ-004 clk_i  in  1  single clock.
REQ-005 rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 reg_req_i  in  reg_req_t  register access from the island's regbus window.
REQ-007 reg_rsp_o  out  reg_rsp_t  register response.
REQ-008 core_start_valid_o  out  1  job launch request to the Ising core.
REQ-009 core_start_ready_i  in  1  core accepts the launch.
REQ-010 core_num_iter_o  out  32  iteration count, stable while valid or busy.
REQ-011 core_abort_o  out  1  one-cycle abort pulse.
REQ-012 core_done_i  in  1  one-cycle job completion pulse.
REQ-013 irq_o  out  1  level interrupt.

Function
REQ-014 Address decode uses addr[4:2] only: 0x00 CTRL, 0x04 STATUS, 0x08 NUM_ITER, 0x0C TIMEOUT_CYC, 0x10 CYCLE_CNT, 0x14 ID; any other offset -> error=1, rdata=0, no side effect.
REQ-015 reg_rsp_o.ready = 1 every cycle; rdata combinational from current register state; writes take effect at the next edge; wstrb ignored (full-word writes).
REQ-016 CTRL: bit0 START (write-1 pulse, reads 0), bit1 ABORT (write-1 pulse, reads 0), bit2 IRQ_EN (RW).
REQ-017 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 TIMEOUT (sticky, W1C), bit3 ABORTED (sticky, W1C).
REQ-018 NUM_ITER, TIMEOUT_CYC RW; CYCLE_CNT, ID RO; write to RO -> error=1, no effect.
REQ-019 FSM states IDLE, REQ, RUN.
- IDLE -> REQ on START write.
- Entering REQ clears DONE, TIMEOUT, ABORTED and CYCLE_CNT.
REQ-020 REQ: core_start_valid_o=1 until core_start_ready_i; on handshake -> RUN the next cycle.
REQ-021 RUN: CYCLE_CNT increments by 1 per cycle and saturates at 0xFFFF_FFFF; core_done_i -> set DONE, -> IDLE.
REQ-022 ABORT write in REQ or RUN -> core_abort_o=1 for exactly one cycle, set ABORTED, -> IDLE; ABORT in IDLE ignored.
REQ-023 Simultaneous core_done_i and ABORT in RUN: done wins (DONE set, no abort pulse).
REQ-024 START while BUSY (REQ/RUN) ignored; NUM_ITER writes while BUSY -> error=1, value unchanged.
REQ-025 BUSY = (state != IDLE).
REQ-026 irq_o = IRQ_EN & (DONE | TIMEOUT | ABORTED), registered, one cycle after the status bit sets.
REQ-027 core_done_i outside RUN ignored.

Reset
REQ-028 On rst_ni low, asynchronously: state IDLE; all registers 0; core_start_valid_o=0, core_abort_o=0, irq_o=0.
REQ-029 Reset mid-job returns to IDLE without an abort pulse; the core is reset by the same rst_ni.

Configuration
REQ-030 Macro LAGD_ISLAND_CTRL_TIMEOUT_EN.
- Defined: in RUN, if TIMEOUT_CYC != 0 and CYCLE_CNT+1 == TIMEOUT_CYC without done -> set TIMEOUT, pulse core_abort_o, -> IDLE; done in the same cycle wins.
- Undefined: TIMEOUT_CYC reads 0, writes ignored without error, TIMEOUT never sets, no comparator logic.

Structure
REQ-031 Register offsets, field bit positions, FSM state enum and ID constant SHALL live in lagd_pkg.
REQ-032 Single module, no sub-modules; the register file and FSM are in one file.

Verification
REQ-033 NUM_ITER=100, START; core ready after 2 cycles, done 50 cycles later -> valid held 3 cycles, DONE=1, CYCLE_CNT=50, BUSY=0.
REQ-034 IRQ_EN=1, job completes -> irq_o=1 next cycle; W1C DONE -> irq_o=0 next cycle.
REQ-035 ABORT written 10 cycles into RUN -> one-cycle core_abort_o, ABORTED=1, BUSY=0; done the same cycle as ABORT -> DONE=1, no abort pulse.
REQ-036 TIMEOUT_EN defined, TIMEOUT_CYC=20, no done -> TIMEOUT=1 and core_abort_o at CYCLE_CNT=20; undefined -> TIMEOUT_CYC reads 0.
REQ-037 Read 0x18, write ID, write NUM_ITER while BUSY -> error=1, no state change; ID reads IslandId.
REQ-038 rst_ni asserted mid-RUN -> all outputs 0 immediately, STATUS=0 after release.
